// File: rtl/pri_sel_pkg.sv
// Shared sizing helpers and defaults for the priority-select round-robin arbiter.
package pri_sel_pkg;

  localparam int P_DEF         = 16;
  localparam int AGE_LIMIT_DEF = 8;

  function automatic int pw_f(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int iw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [pw_f(P_DEF)-1:0] pri_t;

endpackage

// File: rtl/pri_sel_max_tree.sv
// Combinational max-select over {request, effective priority, rotated rank}.
// Rank is highest for the channel at rr_ptr, so equal priorities resolve round-robin.
module pri_sel_max_tree
  import pri_sel_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 4,
  parameter int IW = iw_f(N)
) (
  input  logic [N-1:0][PW-1:0] eff,
  input  logic [N-1:0]         req,
  input  logic [IW-1:0]        rr_ptr,
  output logic [N-1:0]         win_oh,
  output logic [IW-1:0]        win_idx,
  output logic                 any_req
);

  localparam int L  = (N > 1) ? $clog2(N) : 0;
  localparam int NP = 1 << L;
  localparam int KW = 1 + PW + IW;

  // Heap layout: node j has children 2j+1 and 2j+2; leaves start at NP-1.
  logic [KW-1:0] key [2*NP-1];
  logic [IW-1:0] idx [2*NP-1];

  always_comb begin
    int pos;
    pos = 0;
    for (int j = 0; j < 2*NP-1; j++) begin
      key[j] = '0;
      idx[j] = '0;
    end
    for (int i = 0; i < N; i++) begin
      pos = (i - int'(rr_ptr) + N) % N;
      if (req[i]) key[NP-1+i] = {1'b1, eff[i], IW'(N-1-pos)};
      idx[NP-1+i] = IW'(i);
    end
    for (int j = NP-2; j >= 0; j--) begin
      if (key[2*j+1] >= key[2*j+2]) begin
        key[j] = key[2*j+1];
        idx[j] = idx[2*j+1];
      end else begin
        key[j] = key[2*j+2];
        idx[j] = idx[2*j+2];
      end
    end
  end

  assign any_req = key[0][KW-1];
  assign win_idx = idx[0];

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N; i++) win_oh[i] = any_req && (idx[0] == IW'(i));
  end

endmodule

// File: rtl/pri_sel_rr_arb.sv
// Registered N-channel priority arbiter with round-robin tie break and valid/ready output.
// Optional starvation boost compiled in with `PRI_SEL_AGING_EN.
module pri_sel_rr_arb
  import pri_sel_pkg::*;
#(
  parameter int N         = 4,
  parameter int P         = P_DEF,
  parameter int AGE_LIMIT = AGE_LIMIT_DEF,
  localparam int PW       = pw_f(P),
  localparam int IW       = iw_f(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0][PW-1:0] pri_in,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [N-1:0]         grant_out,
  output logic [IW-1:0]        grant_idx,
  output logic [PW-1:0]        pri_out
);

  logic [N-1:0]         req;
  logic [N-1:0][PW-1:0] eff;
  logic                 load;
  logic                 xfer;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        rr_nxt;
  logic [N-1:0]         win_oh;
  logic [IW-1:0]        win_idx;
  logic                 any_req;

  assign load = !valid_out || ready_in;
  assign xfer = valid_out && ready_in;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = (pri_in[i] != '0);
  end

  // The load in a transfer cycle already sees the advanced pointer.
  always_comb begin
    rr_nxt = rr_ptr;
    if (N == 1)
      rr_nxt = '0;
    else if (xfer)
      rr_nxt = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
  end

`ifdef PRI_SEL_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT+1);

  logic [AW-1:0] age_cnt [N];
  logic [AW-1:0] age_nxt [N];

  // Boost is judged on the post-update count so the loss being handed off now counts.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_nxt[i] = age_cnt[i];
      if (load) begin
        if (!req[i] || (xfer && grant_idx == IW'(i)))
          age_nxt[i] = '0;
        else if (xfer && age_cnt[i] != AW'(AGE_LIMIT))
          age_nxt[i] = age_cnt[i] + 1'b1;
      end
      eff[i] = (req[i] && age_nxt[i] == AW'(AGE_LIMIT)) ? PW'(P-1) : pri_in[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) age_cnt[i] <= '0;
      else     age_cnt[i] <= age_nxt[i];
    end
  end
`else
  assign eff = pri_in;
`endif

  pri_sel_max_tree #(.N(N), .PW(PW), .IW(IW)) u_max_tree (
    .eff     (eff),
    .req     (req),
    .rr_ptr  (rr_nxt),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      grant_out <= '0;
      grant_idx <= '0;
      pri_out   <= '0;
      rr_ptr    <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (load) begin
        valid_out <= any_req;
        grant_out <= win_oh;
        grant_idx <= any_req ? win_idx : '0;
        pri_out   <= any_req ? pri_in[win_idx] : '0;
      end
    end
  end

endmodule
